// File: rtl/pll_reset_sequencer_pkg.sv
// Shared definitions for the PLL reset sequencer: state codes, state width and
// the counter sizing helper.
package pll_reset_sequencer_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] S_PLL_RST   = 2'd0;
    localparam logic [STATE_W-1:0] S_WAIT_LOCK = 2'd1;
    localparam logic [STATE_W-1:0] S_STABLE    = 2'd2;
    localparam logic [STATE_W-1:0] S_RUN       = 2'd3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Generic two-flop synchronizer, async active-low reset to 0.
// Reused wherever a level crosses into a new clock domain.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives rPLL RESET, qualifies LOCK and releases the downstream system reset
// only after lock has been continuously stable; retries on lock timeout.
module pll_reset_sequencer
    import pll_reset_sequencer_pkg::*;
#(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 27000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int RETRY_W        = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pll_lock_i,
    input  logic               soft_rst_i,
    output logic               pll_rst_o,
    output logic               sys_rst_n_o,
    output logic               ready_o,
    output logic [RETRY_W-1:0] retry_cnt_o,
    output logic [STATE_W-1:0] state_o
);

    localparam int CNT_W = $clog2(max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)) + 1;

    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

    logic               lock_s;
    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_nxt;
    logic [CNT_W-1:0]   count;
    logic [RETRY_W-1:0] retry_cnt;
    logic               retry_inc;
    logic               transition;

    // LOCK is the only asynchronous input; nothing else looks at the raw pin.
    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_lock_i),
        .q     (lock_s)
    );

    always_comb begin
        state_nxt = state;
        retry_inc = 1'b0;
        if (soft_rst_i) begin
            state_nxt = S_PLL_RST;
        end else begin
            case (state)
                S_PLL_RST: begin
                    if (count == PLL_RST_LAST)
                        state_nxt = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    // Lock arriving on the timeout cycle wins over a retry.
                    if (lock_s) begin
                        state_nxt = S_STABLE;
                    end else if (count == TIMEOUT_LAST) begin
                        state_nxt = S_PLL_RST;
                        retry_inc = 1'b1;
                    end
                end
                S_STABLE: begin
                    if (!lock_s)
                        state_nxt = S_WAIT_LOCK;
                    else if (count == STABLE_LAST)
                        state_nxt = S_RUN;
                end
                default: begin
                    if (!lock_s)
                        state_nxt = S_WAIT_LOCK;
                end
            endcase
        end
    end

    // A soft request inside S_PLL_RST still restarts the reset pulse.
    assign transition = soft_rst_i || (state_nxt != state);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_PLL_RST;
            count     <= '0;
            retry_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (transition)
                count <= '0;
            else
                count <= count + CNT_W'(1);
            if (retry_inc && (retry_cnt != {RETRY_W{1'b1}}))
                retry_cnt <= retry_cnt + RETRY_W'(1);
        end
    end

    assign pll_rst_o   = (state == S_PLL_RST);
    assign sys_rst_n_o = (state == S_RUN);
    assign ready_o     = (state == S_RUN);
    assign retry_cnt_o = retry_cnt;
    assign state_o     = state;

endmodule
